// File: rtl/bcd_display_sequencer.sv
// Byte-serial BCD display sequencer.
// Captures a block of NBYTES bytes, feeds them one at a time (MSB byte first)
// to a shared combinational binary-to-BCD encoder, and presents each encoded
// result on a valid/ready output stream. A done pulse follows the last
// accepted byte.
module bcd_display_sequencer #(
  parameter int NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [8*NBYTES-1:0]   block_in,
  output logic [7:0]            enc_bin,
  input  logic [11:0]           enc_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [11:0]           out_bcd,
  output logic [3:0]            out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_next;

  logic [8*NBYTES-1:0] shadow;
  logic [3:0]          idx;
  logic [7:0]          byte_arr [NBYTES];
  logic [7:0]          sel_byte;
  logic                capture;
  logic                load_out;
  logic                advance;

  // Split the shadow block into bytes; byte 0 sits in the most significant slot.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign byte_arr[gi] = shadow[8*(NBYTES-gi)-1 -: 8];
    end
  endgenerate

  // State register; reset drops any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Abort overrides everything, including a pending
  // handshake or a simultaneous start in IDLE.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load_out   = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          capture    = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          load_out   = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            advance    = 1'b1;
            state_next = CONVERT;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Block shadow, byte index and the registered output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      idx      <= '0;
      out_bcd  <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else begin
      if (capture) begin
        shadow <= block_in;
        idx    <= '0;
      end
      if (advance) begin
        idx <= idx + 4'd1;
      end
      if (load_out) begin
        out_bcd  <= enc_bcd;
        out_idx  <= idx;
        out_last <= (idx == LAST_IDX);
      end
    end
  end

  // Select the current shadow byte; only driven to the encoder while converting.
  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == 4'(i)) begin
        sel_byte = byte_arr[i];
      end
    end
    enc_bin = (state == CONVERT) ? sel_byte : 8'h00;
  end

  assign out_valid = (state == PRESENT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Testbench for bcd_display_sequencer: one 16-byte instance and one 1-byte
// instance, each driven by a behavioural binary-to-BCD encoder. Expected
// output words are queued when a block is started and popped on handshake.
module tb_bcd_display_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [11:0] bin2bcd(input logic [7:0] b);
    int v;
    v = int'(b);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // 16-byte instance
  logic         start_a, abort_a, ready_a;
  logic [127:0] block_a;
  logic [7:0]   enc_bin_a;
  logic [11:0]  enc_bcd_a, bcd_a;
  logic         valid_a, last_a, busy_a, done_a;
  logic [3:0]   idx_a;

  assign enc_bcd_a = bin2bcd(enc_bin_a);

  bcd_display_sequencer #(.NBYTES(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .block_in(block_a), .enc_bin(enc_bin_a), .enc_bcd(enc_bcd_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_bcd(bcd_a),
    .out_idx(idx_a), .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  // 1-byte instance
  logic         start_b, abort_b, ready_b;
  logic [7:0]   block_b;
  logic [7:0]   enc_bin_b;
  logic [11:0]  enc_bcd_b, bcd_b;
  logic         valid_b, last_b, busy_b, done_b;
  logic [3:0]   idx_b;

  assign enc_bcd_b = bin2bcd(enc_bin_b);

  bcd_display_sequencer #(.NBYTES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .block_in(block_b), .enc_bin(enc_bin_b), .enc_bcd(enc_bcd_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_bcd(bcd_b),
    .out_idx(idx_b), .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  typedef struct packed {
    logic [11:0] bcd;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  task automatic push_block_a(input logic [127:0] blk);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.bcd  = bin2bcd(blk[127-8*i -: 8]);
      e.idx  = 4'(i);
      e.last = (i == 15);
      sb_a.push_back(e);
    end
  endtask

  // Pulse start for one edge; t returns the edge number that accepted it.
  task automatic kick_a(input logic [127:0] blk, output int t);
    block_a = blk;
    start_a = 1'b1;
    push_block_a(blk);
    @(negedge clk);
    t = cyc;
    start_a = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_a = 0; abort_a = 0; ready_a = 0; block_a = '0;
    start_b = 0; abort_b = 0; ready_b = 0; block_b = '0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({valid_a, bcd_a, idx_a, last_a, busy_a, done_a, enc_bin_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got %h required 0",
               {valid_a, bcd_a, idx_a, last_a, busy_a, done_a, enc_bin_a});
    end
    n_tests++;
    if ({valid_b, bcd_b, idx_b, last_b, busy_b, done_b, enc_bin_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got %h required 0",
               {valid_b, bcd_b, idx_b, last_b, busy_b, done_b, enc_bin_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy got %b required 0", busy_a);
    end
  endtask

  task automatic test_idle_abort;
    start_a = 1'b1; abort_a = 1'b1; block_a = {16{8'h11}};
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    n_tests++;
    if ({busy_a, valid_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_abort_wins: busy/valid got %b required 00", {busy_a, valid_a});
    end
  endtask

  task automatic test_stream;
    logic [127:0] blk;
    int   t, done_cnt;
    bit   first_seen;
    exp_t e;
    blk = {8'hFF, 8'h00, {14{8'h80}}};
    ready_a = 1'b1;
    first_seen = 0; done_cnt = 0;
    kick_a(blk, t);
    for (int c = 0; c < 80; c++) begin
      if (busy_a && !valid_a && !done_a && sb_a.size() > 0) begin
        n_tests++;
        if (enc_bin_a !== blk[127-8*int'(sb_a[0].idx) -: 8]) begin
          n_fail++;
          $display("FAIL stream_enc_bin: got %h required %h", enc_bin_a,
                   blk[127-8*int'(sb_a[0].idx) -: 8]);
        end
      end
      if (valid_a) begin
        if (!first_seen) begin
          first_seen = 1;
          n_tests++;
          if (cyc + 1 !== t + 2) begin
            n_fail++;
            $display("FAIL stream_first_valid: edge %0d required %0d", cyc + 1, t + 2);
          end
        end
        n_tests++;
        if (enc_bin_a !== 8'h00) begin
          n_fail++;
          $display("FAIL stream_enc_bin_idle: got %h required 00", enc_bin_a);
        end
        n_tests++;
        if (sb_a.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra_output: got idx %0d required none", idx_a);
        end else begin
          e = sb_a.pop_front();
          if ({bcd_a, idx_a, last_a} !== e) begin
            n_fail++;
            $display("FAIL stream_data: got bcd %h idx %0d last %b required bcd %h idx %0d last %b",
                     bcd_a, idx_a, last_a, e.bcd, e.idx, e.last);
          end
        end
      end
      if (done_a) begin
        done_cnt++;
        if (done_cnt == 1) begin
          n_tests++;
          if (cyc + 1 !== t + 33) begin
            n_fail++;
            $display("FAIL stream_done_time: edge %0d required %0d", cyc + 1, t + 33);
          end
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (done_cnt !== 1 || sb_a.size() !== 0) begin
      n_fail++;
      $display("FAIL stream_complete: done pulses %0d, left %0d required 1, 0",
               done_cnt, sb_a.size());
    end
  endtask

  task automatic test_stall_and_restart;
    logic [127:0] blk;
    int   t, stall, done_cnt;
    bit   restarted;
    exp_t e;
    for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(i * 7 + 1);
    blk[127-24 -: 8] = 8'h2A;
    ready_a = 1'b1;
    stall = 0; done_cnt = 0; restarted = 0;
    kick_a(blk, t);
    block_a = ~blk;
    for (int c = 0; c < 120; c++) begin
      start_a = 1'b0;
      if (valid_a) begin
        if (idx_a == 4'd3 && stall < 5) begin
          ready_a = 1'b0;
          stall++;
          n_tests++;
          if ({bcd_a, idx_a} !== {12'h042, 4'd3}) begin
            n_fail++;
            $display("FAIL stall_hold: got bcd %h idx %0d required 042 idx 3", bcd_a, idx_a);
          end
        end else begin
          ready_a = 1'b1;
          n_tests++;
          if (sb_a.size() == 0) begin
            n_fail++;
            $display("FAIL stall_extra_output: got idx %0d required none", idx_a);
          end else begin
            e = sb_a.pop_front();
            if ({bcd_a, idx_a, last_a} !== e) begin
              n_fail++;
              $display("FAIL stall_data: got bcd %h idx %0d last %b required bcd %h idx %0d last %b",
                       bcd_a, idx_a, last_a, e.bcd, e.idx, e.last);
            end
          end
        end
        if (idx_a == 4'd5 && !restarted) begin
          restarted = 1;
          start_a = 1'b1;
          block_a = {16{8'h55}};
        end
      end
      if (done_a) done_cnt++;
      @(negedge clk);
    end
    start_a = 1'b0;
    n_tests++;
    if (done_cnt !== 1 || sb_a.size() !== 0 || stall !== 5 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_complete: done %0d left %0d stalls %0d busy %b required 1 0 5 0",
               done_cnt, sb_a.size(), stall, busy_a);
    end
  endtask

  task automatic test_abort;
    logic [127:0] blk, blk2;
    int   t;
    bit   aborted;
    exp_t e;
    for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(i * 3 + 5);
    for (int i = 0; i < 16; i++) blk2[127-8*i -: 8] = 8'(250 - i * 11);
    ready_a = 1'b1;
    aborted = 0;
    kick_a(blk, t);
    for (int c = 0; c < 60 && !aborted; c++) begin
      if (valid_a) begin
        if (idx_a == 4'd7) begin
          abort_a = 1'b1;
          ready_a = 1'b0;
          aborted = 1;
        end else begin
          e = sb_a.pop_front();
          n_tests++;
          if ({bcd_a, idx_a, last_a} !== e) begin
            n_fail++;
            $display("FAIL abort_pre_data: got bcd %h idx %0d required bcd %h idx %0d",
                     bcd_a, idx_a, e.bcd, e.idx);
          end
        end
      end
      @(negedge clk);
    end
    abort_a = 1'b0;
    sb_a.delete();
    n_tests++;
    if (!aborted || {valid_a, busy_a, done_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_exit: reached %b valid/busy/done %b required 1 000",
               aborted, {valid_a, busy_a, done_a});
    end
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: done %b busy %b required 0 0", done_a, busy_a);
      end
      @(negedge clk);
    end
    ready_a = 1'b0;
    kick_a(blk2, t);
    @(negedge clk);
    n_tests++;
    if (valid_a !== 1'b1 || {bcd_a, idx_a, last_a} !== sb_a[0] || cyc + 1 !== t + 2) begin
      n_fail++;
      $display("FAIL abort_restart: valid %b bcd %h idx %0d edge %0d required 1 %h 0 %0d",
               valid_a, bcd_a, idx_a, cyc + 1, sb_a[0].bcd, t + 2);
    end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    sb_a.delete();
    n_tests++;
    if ({valid_a, busy_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_in_present: valid/busy got %b required 00", {valid_a, busy_a});
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] blk;
    int   t;
    bit   hit;
    exp_t e;
    for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(i * 13 + 2);
    ready_a = 1'b1;
    hit = 0;
    kick_a(blk, t);
    for (int c = 0; c < 60 && !hit; c++) begin
      if (valid_a && idx_a == 4'd9) begin
        ready_a = 1'b0;
        hit = 1;
      end else begin
        if (valid_a) begin
          e = sb_a.pop_front();
          n_tests++;
          if ({bcd_a, idx_a, last_a} !== e) begin
            n_fail++;
            $display("FAIL rstmid_pre_data: got bcd %h idx %0d required bcd %h idx %0d",
                     bcd_a, idx_a, e.bcd, e.idx);
          end
        end
        @(negedge clk);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (!hit || {valid_a, bcd_a, idx_a, last_a, busy_a, done_a, enc_bin_a} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: reached %b outputs %h required 1 0", hit,
               {valid_a, bcd_a, idx_a, last_a, busy_a, done_a, enc_bin_a});
    end
    sb_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_a = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if ({valid_a, busy_a} !== 2'b00) begin
        n_fail++;
        $display("FAIL rstmid_stays_idle: valid/busy got %b required 00", {valid_a, busy_a});
      end
    end
  endtask

  task automatic test_single_byte;
    logic [7:0] vals [4];
    exp_t e;
    vals[0] = 8'h63; vals[1] = 8'h00; vals[2] = 8'hFF; vals[3] = 8'h0A;
    ready_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      block_b = vals[k];
      start_b = 1'b1;
      e.bcd = bin2bcd(vals[k]); e.idx = 4'd0; e.last = 1'b1;
      sb_b.push_back(e);
      @(negedge clk);
      start_b = 1'b0;
      block_b = 8'h77;
      n_tests++;
      if (enc_bin_b !== vals[k]) begin
        n_fail++;
        $display("FAIL single_enc_bin: got %h required %h", enc_bin_b, vals[k]);
      end
      @(negedge clk);
      e = sb_b.pop_front();
      n_tests++;
      if (valid_b !== 1'b1 || {bcd_b, idx_b, last_b} !== e) begin
        n_fail++;
        $display("FAIL single_data: valid %b bcd %h idx %0d last %b required 1 %h 0 1",
                 valid_b, bcd_b, idx_b, last_b, e.bcd);
      end
      @(negedge clk);
      n_tests++;
      if ({done_b, valid_b} !== 2'b10) begin
        n_fail++;
        $display("FAIL single_done: done/valid got %b required 10", {done_b, valid_b});
      end
      @(negedge clk);
      n_tests++;
      if ({done_b, busy_b} !== 2'b00) begin
        n_fail++;
        $display("FAIL single_done_once: done/busy got %b required 00", {done_b, busy_b});
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_abort();
    test_stream();
    test_stall_and_restart();
    test_abort();
    test_reset_mid();
    test_single_byte();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_display_sequencer.md
BCD_DISPLAY_SEQUENCER -- requirements
Module: bcd_display_sequencer

Interface
REQ-001 Parameter: NBYTES, 16, number of bytes per block (legal range 1..16).
REQ-002 clk  in  1  single clock; all sequential logic on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request to convert one block; sampled in IDLE only.
REQ-005 abort  in  1  synchronous cancel of current block.
REQ-006 block_in  in  8*NBYTES  block data; byte 0 = block_in[8*NBYTES-1 -: 8] (MSB first).
REQ-007 enc_bin  out  8  byte driven to the shared binary-to-BCD encoder.
REQ-008 enc_bcd  in  12  3-digit BCD result returned combinationally by the encoder.
REQ-009 out_valid  out  1  out_bcd/out_idx/out_last valid.
REQ-010 out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-011 out_bcd  out  12  registered BCD of current byte (hundreds in [11:8]).
REQ-012 out_idx  out  4  byte index of out_bcd.
REQ-013 out_last  out  1  high with out_valid when out_idx == NBYTES-1.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse after last byte is accepted.

Function
REQ-016 FSM states SHALL be IDLE, CONVERT, PRESENT, DONE.
REQ-017 IDLE: start=1 and abort=0 SHALL capture block_in into an internal shadow register, clear idx to 0, go to CONVERT.
REQ-018 CONVERT: enc_bin SHALL equal shadow byte[idx]; enc_bcd SHALL be registered into out_bcd, idx into out_idx; next state PRESENT with out_valid=1.
REQ-019 PRESENT: out_bcd, out_idx, out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 PRESENT with out_ready=1: if idx==NBYTES-1 go to DONE, else idx+1 and go to CONVERT; out_valid SHALL drop the following cycle.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE.
REQ-022 enc_bin SHALL be 8'h00 in all states other than CONVERT.
REQ-023 Latency: start accepted at edge T -> first out_valid at edge T+2; with out_ready tied high, one byte per 2 cycles; done high in cycle following last handshake (T+2*NBYTES+1 for NBYTES bytes).
REQ-024 start while busy=1 SHALL be ignored; block_in changes after capture SHALL not affect output.
REQ-025 abort=1 in any non-IDLE state SHALL return to IDLE next edge, clear out_valid, no done pulse; abort and start together in IDLE: abort wins, no capture.
REQ-026 idx SHALL never exceed NBYTES-1; no wrap to 0 within a block.
REQ-027 NBYTES=1: single byte with out_last=1, then DONE.
REQ-028 out_bcd SHALL be taken unmodified from enc_bcd; no arithmetic on it in this block.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, idx=0, out_valid=0, out_bcd=0, out_idx=0, out_last=0, busy=0, done=0, enc_bin=0, shadow=0.
REQ-030 Reset mid-block SHALL discard the block; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-031 NBYTES=16, block byte0=8'hFF, byte1=8'h00, rest 8'h80, out_ready=1, start pulse -> out_bcd 12'h255 idx0, 12'h000 idx1, 12'h128 idx2..15, out_last on idx15, done at T+33.
REQ-032 Stall: out_ready=0 for 5 cycles while out_valid on idx3 (byte 8'h2A) -> out_bcd held at 12'h042, idx 3, for all 5 cycles; advances only after ready.
REQ-033 start pulsed again at idx5 with different block_in -> ignored; remaining outputs from original block; exactly one done.
REQ-034 abort at idx7 -> out_valid=0 next cycle, busy=0, no done; new start then yields idx0 of new block at T+2.
REQ-035 rst_n low during PRESENT idx9 -> all outputs 0 asynchronously; after release, no out_valid until next start.
REQ-036 NBYTES=1, byte 8'h63 -> single out_bcd 12'h099 with out_last=1, done pulse next cycle after handshake.
